// File: rtl/win_detector.sv
// Connect-4 (4x4) result checker: snapshots the board on each committed move and
// scans the ten four-in-a-line patterns one per clock, latching a final result.
module win_detector (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] gameboard,
    input  logic [15:0] players_cells,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [3:0]  win_line,
    output logic        game_over
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

    localparam int NUM_LINES = 10;
    localparam logic [3:0] LAST_LINE = 4'(NUM_LINES - 1);

    // Index 0 in the low slot: rows 0-3, columns 0-3, main diagonal, anti-diagonal.
    localparam logic [NUM_LINES-1:0][15:0] LINE_MASK = {
        16'h1248, 16'h8421,
        16'h8888, 16'h4444, 16'h2222, 16'h1111,
        16'hF000, 16'h0F00, 16'h00F0, 16'h000F
    };

    state_t      state, state_nxt;
    logic [3:0]  line_cnt, line_cnt_nxt;
    logic [15:0] snap_board, snap_board_nxt;
    logic [15:0] snap_cells, snap_cells_nxt;
    logic [1:0]  winner_nxt;
    logic [3:0]  win_line_nxt;
    logic        game_over_nxt;
    logic [15:0] p1_hit, p2_hit;

    // Per-line match flags, padded to 16 so any counter value indexes safely.
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_line
            if (g < NUM_LINES) begin : g_real
                assign p1_hit[g] = (snap_board & snap_cells  & LINE_MASK[g]) == LINE_MASK[g];
                assign p2_hit[g] = (snap_board & ~snap_cells & LINE_MASK[g]) == LINE_MASK[g];
            end else begin : g_pad
                assign p1_hit[g] = 1'b0;
                assign p2_hit[g] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_nxt      = state;
        line_cnt_nxt   = line_cnt;
        snap_board_nxt = snap_board;
        snap_cells_nxt = snap_cells;
        winner_nxt     = winner;
        win_line_nxt   = win_line;
        game_over_nxt  = game_over;

        case (state)
            IDLE: begin
                if (start) begin
                    snap_board_nxt = gameboard;
                    snap_cells_nxt = players_cells;
                    winner_nxt     = 2'b00;
                    win_line_nxt   = 4'd0;
                    line_cnt_nxt   = 4'd0;
                    state_nxt      = SCAN;
                end
            end
            SCAN: begin
                if (p1_hit[line_cnt]) begin
                    winner_nxt   = 2'b01;
                    win_line_nxt = line_cnt;
                    state_nxt    = REPORT;
                end else if (p2_hit[line_cnt]) begin
                    winner_nxt   = 2'b10;
                    win_line_nxt = line_cnt;
                    state_nxt    = REPORT;
                end else if (line_cnt == LAST_LINE) begin
                    // No line anywhere: a full board is a draw, otherwise play continues.
                    winner_nxt = (&snap_board) ? 2'b11 : 2'b00;
                    state_nxt  = REPORT;
                end else begin
                    line_cnt_nxt = line_cnt + 4'd1;
                end
            end
            REPORT: begin
                if (winner == 2'b00) begin
                    state_nxt = IDLE;
                end else begin
                    game_over_nxt = 1'b1;
                    state_nxt     = OVER;
                end
            end
            OVER: ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            line_cnt   <= 4'd0;
            snap_board <= 16'h0000;
            snap_cells <= 16'h0000;
            winner     <= 2'b00;
            win_line   <= 4'd0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nxt;
            line_cnt   <= line_cnt_nxt;
            snap_board <= snap_board_nxt;
            snap_cells <= snap_cells_nxt;
            winner     <= winner_nxt;
            win_line   <= win_line_nxt;
            game_over  <= game_over_nxt;
        end
    end

    assign busy = (state == SCAN) || (state == REPORT);
    assign done = (state == REPORT);

endmodule

// File: tb/tb_win_detector.sv
// Directed bench for win_detector: vector table of boards with hand-derived results,
// plus sequences for sticky game-over, mid-scan disturbance and reset behaviour.
module tb_win_detector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] gameboard = 16'h0000;
    logic [15:0] players_cells = 16'h0000;
    logic        busy, done, game_over;
    logic [1:0]  winner;
    logic [3:0]  win_line;

    int n_cmp = 0;
    int n_err = 0;

    win_detector dut (
        .clk(clk), .reset(reset), .start(start),
        .gameboard(gameboard), .players_cells(players_cells),
        .busy(busy), .done(done), .winner(winner),
        .win_line(win_line), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] board;
        logic [15:0] cells;
        logic [1:0]  winner;
        logic [3:0]  line;
        int          cycle;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Called in the cycle that becomes cycle 0; returns in cycle 1.
    task automatic start_move(input logic [15:0] b, input logic [15:0] c);
        gameboard     = b;
        players_cells = c;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!done && cyc < 30) begin
            step();
            cyc++;
        end
        check("done_seen", int'(done), 1);
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0] = '{16'h0000, 16'h0000, 2'b00, 4'd0, 11};  // empty board
        vecs[1] = '{16'h1111, 16'h1111, 2'b01, 4'd4, 6};   // P1 column 0
        vecs[2] = '{16'h000F, 16'h0000, 2'b10, 4'd0, 2};   // P2 bottom row
        vecs[3] = '{16'h1248, 16'h1248, 2'b01, 4'd9, 11};  // P1 anti-diagonal
        vecs[4] = '{16'hFFFF, 16'hC3C3, 2'b11, 4'd0, 11};  // full board, no line: draw
        vecs[5] = '{16'hFFFF, 16'h5A5A, 2'b10, 4'd8, 10};  // main diagonal all P2
        vecs[6] = '{16'h0007, 16'h000F, 2'b00, 4'd0, 11};  // owner bit set on empty cell
        vecs[7] = '{16'hFFFF, 16'hFFFF, 2'b01, 4'd0, 2};   // full board but a win, not a draw
        vecs[8] = '{16'hF000, 16'hF000, 2'b01, 4'd3, 5};   // top row P1

        step();
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_win_line", int'(win_line), 0);
        check("rst_game_over", int'(game_over), 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            start_move(vecs[i].board, vecs[i].cells);
            check($sformatf("v%0d_busy_scan", i), int'(busy), 1);
            wait_done(1, cyc);
            check($sformatf("v%0d_cycle", i), cyc, vecs[i].cycle);
            check($sformatf("v%0d_winner", i), int'(winner), int'(vecs[i].winner));
            check($sformatf("v%0d_win_line", i), int'(win_line), int'(vecs[i].line));
            check($sformatf("v%0d_busy_report", i), int'(busy), 1);
            step();
            check($sformatf("v%0d_done_pulse", i), int'(done), 0);
            check($sformatf("v%0d_busy_after", i), int'(busy), 0);
            check($sformatf("v%0d_game_over", i), int'(game_over), int'(vecs[i].winner != 2'b00));
            check($sformatf("v%0d_winner_hold", i), int'(winner), int'(vecs[i].winner));
            check($sformatf("v%0d_line_hold", i), int'(win_line), int'(vecs[i].line));
        end

        // Game over is sticky: later starts are ignored until reset.
        do_reset();
        start_move(16'h1111, 16'h1111);
        wait_done(1, cyc);
        step();
        start_move(16'h000F, 16'h0000);
        check("over_busy", int'(busy), 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) seen = 1;
            step();
        end
        check("over_no_activity", seen, 0);
        check("over_game_over", int'(game_over), 1);
        check("over_winner", int'(winner), 1);
        check("over_win_line", int'(win_line), 4);
        do_reset();
        check("over_rst_game_over", int'(game_over), 0);
        check("over_rst_winner", int'(winner), 0);
        check("over_rst_win_line", int'(win_line), 0);

        // Start and board changes during a scan of an empty snapshot have no effect.
        start_move(16'h0000, 16'h0000);
        step();
        gameboard     = 16'hFFFF;
        players_cells = 16'hFFFF;
        start         = 1'b1;
        step(); step(); step();
        start = 1'b0;
        wait_done(5, cyc);
        check("mid_cycle", cyc, 11);
        check("mid_winner", int'(winner), 0);
        check("mid_win_line", int'(win_line), 0);
        step();
        check("mid_busy_idle", int'(busy), 0);
        check("mid_game_over", int'(game_over), 0);
        // Earliest accepted start is the cycle right after REPORT.
        start_move(16'h000F, 16'h000F);
        check("b2b_busy", int'(busy), 1);
        wait_done(1, cyc);
        check("b2b_cycle", cyc, 2);
        check("b2b_winner", int'(winner), 1);

        // Reset in cycle 5 of a scan that would otherwise find a win on line 9.
        do_reset();
        start_move(16'h1248, 16'h1248);
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid_busy", int'(busy), 0);
        check("rmid_done", int'(done), 0);
        check("rmid_winner", int'(winner), 0);
        check("rmid_game_over", int'(game_over), 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) seen = 1;
            step();
        end
        check("rmid_no_done", seen, 0);

        // Reset takes priority over start in the same cycle.
        gameboard     = 16'h000F;
        players_cells = 16'h0000;
        start         = 1'b1;
        reset         = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        check("rst_vs_start_busy", int'(busy), 0);
        step();
        check("rst_vs_start_done", int'(done), 0);
        check("rst_vs_start_winner", int'(winner), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
